// File: rtl/hpdl1414_scan_ctrl_if.sv
// Display-memory read port and HPDL1414 bus seen by the scan controller.
// master = controller side, slave = memory/display side.
interface hpdl1414_scan_ctrl_if;
  logic       i_enable;
  logic       o_read_enable;
  logic [3:0] o_read_address;
  logic [7:0] i_read_data;
  logic       o_caret_strobe;
  logic [6:0] o_hp_data;
  logic [1:0] o_hp_addr;
  logic [3:0] o_hp_wr_n;
  logic       o_busy;
  logic       o_frame_done;

  modport master (
    input  i_enable, i_read_data,
    output o_read_enable, o_read_address, o_caret_strobe,
           o_hp_data, o_hp_addr, o_hp_wr_n, o_busy, o_frame_done
  );

  modport slave (
    output i_enable, i_read_data,
    input  o_read_enable, o_read_address, o_caret_strobe,
           o_hp_data, o_hp_addr, o_hp_wr_n, o_busy, o_frame_done
  );
endinterface

// File: rtl/hpdl1414_scan_ctrl.sv
// Scans 16 display-memory bytes onto four HPDL1414 chips: 2+SETUP+STROBE+HOLD cycles per char,
// no backpressure (fixed timing). Caret blink counter only when HPDL_CARET_BLINK_EN is defined.
module hpdl1414_scan_ctrl #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int BLINK_DIV     = 12_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  hpdl1414_scan_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_index, w_index_nxt;
  logic        w_frame_done_nxt;
  logic [1:0]  r_chip;

  logic        r_read_enable;
  logic [3:0]  r_read_address;
  logic [6:0]  r_hp_data;
  logic [1:0]  r_hp_addr;
  logic [3:0]  r_hp_wr_n;
  logic        r_busy;
  logic        r_frame_done;

  // Fold the byte into the 64-glyph HPDL1414 set: lowercase -> uppercase, controls/high -> space.
  function automatic logic [6:0] map_char(input logic [7:0] b);
    logic [6:0] m;
    if (b >= 8'h20 && b <= 8'h5F)
      m = b[6:0];
    else if (b >= 8'h60 && b <= 8'h7F)
      m = b[6:0] - 7'h20;
    else
      m = 7'h20;
    return m;
  endfunction

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_index_nxt      = r_index;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_enable) begin
          w_state_nxt = S_READ;
          w_index_nxt = 4'd0;
        end
      end
      S_READ: w_state_nxt = S_LATCH;
      S_LATCH: begin
        w_state_nxt = S_SETUP;
        w_cnt_nxt   = 16'd0;
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_STROBE: begin
        if (r_cnt == STROBE_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt = 16'd0;
          if (r_index != 4'd15) begin
            w_index_nxt = r_index + 4'd1;
            w_state_nxt = S_READ;
          end else begin
            // Enable is only sampled at frame boundaries so a frame always completes.
            w_frame_done_nxt = 1'b1;
            w_index_nxt      = 4'd0;
            w_state_nxt      = bus.i_enable ? S_READ : S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_index <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_index <= w_index_nxt;
    end
  end

  // Outputs are registered from the next-state decode so the strobes are glitch-free.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_read_enable  <= 1'b0;
      r_read_address <= 4'd0;
      r_hp_data      <= 7'd0;
      r_hp_addr      <= 2'd0;
      r_chip         <= 2'd0;
      r_hp_wr_n      <= 4'hF;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_read_enable <= (w_state_nxt == S_READ);
      if (w_state_nxt == S_READ)
        r_read_address <= w_index_nxt;
      if (r_state == S_LATCH) begin
        r_hp_data <= map_char(bus.i_read_data);
        r_hp_addr <= 2'd3 - r_index[1:0];
        r_chip    <= r_index[3:2];
      end
      r_hp_wr_n    <= (w_state_nxt == S_STROBE) ? ~(4'b0001 << r_chip) : 4'hF;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.o_read_enable  = r_read_enable;
  assign bus.o_read_address = r_read_address;
  assign bus.o_hp_data      = r_hp_data;
  assign bus.o_hp_addr      = r_hp_addr;
  assign bus.o_hp_wr_n      = r_hp_wr_n;
  assign bus.o_busy         = r_busy;
  assign bus.o_frame_done   = r_frame_done;

`ifdef HPDL_CARET_BLINK_EN
  localparam int                BW         = $clog2(BLINK_DIV);
  localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_caret;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_blink_cnt <= '0;
      r_caret     <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_caret     <= ~r_caret;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign bus.o_caret_strobe = r_caret;
`else
  // No blink: caret phase is permanently "show"; the BLINK_DIV term folds to constant 1.
  assign bus.o_caret_strobe = 1'b1 | (BLINK_DIV < 2);
`endif

endmodule
